mem_io_responder: RTL

- Memory-side responder for the byte-serial RAM bus driven by the memory controller: address, write strobe, and one byte in and one byte out per cycle.
- Holds the unified instruction/data RAM and decodes the memory-mapped IO window.
- Buffers console output bytes in a paced TX FIFO.
- Drives the io_buffer_full back-pressure signal that freezes the controller.

---
 rtl/mem_io_responder_if.sv | 25 ++
 rtl/mem_io_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-serial RAM bus between the memory controller (master) and the memory/IO responder (slave).
// io_buffer_full travels back on the bus so the controller can freeze in the same cycle.
interface mem_io_responder_if;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;

    modport master (
        output mem_addr,
        output mem_wr,
        output mem_din,
        input  mem_dout,
        input  io_buffer_full
    );

    modport slave (
        input  mem_addr,
        input  mem_wr,
        input  mem_din,
        output mem_dout,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: unified byte RAM, memory-mapped IO window, and a paced TX FIFO
// whose occupancy drives back-pressure to the controller.
module mem_io_responder #(
    parameter int          ADDR_WIDTH  = 17,
    parameter logic [31:0] IO_BASE     = 32'h30000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FULL_MARGIN = 2,
    parameter int          TX_INTERVAL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_i,
    mem_io_responder_if.slave    bus,
    input  logic                 io_rx_valid_i,
    input  logic [7:0]           io_rx_data_i,
    output logic                 io_rx_pop_o,
    output logic                 io_tx_valid_o,
    output logic [7:0]           io_tx_data_o,
    input  logic                 io_tx_ready_i,
    output logic                 sim_halt_o,
    output logic                 io_overflow_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PACE_W = (TX_INTERVAL > 1) ? $clog2(TX_INTERVAL) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_LVL    = CNT_W'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(TX_INTERVAL - 1);
    localparam logic [31:0]       IO_TX_ADDR  = IO_BASE;
    localparam logic [31:0]       IO_CTL_ADDR = IO_BASE + 32'd4;
    // A zero margin build disables back-pressure entirely so the overflow path is reachable.
    localparam bit                FULL_EN     = (FULL_MARGIN != 0);

    logic [7:0] ram [2**ADDR_WIDTH];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic              halt_q, halt_d;
    logic              overflow_q, overflow_d;
    logic              dout_ram_q, dout_ram_d;
    logic [7:0]        io_dout_q, io_dout_d;
    logic [7:0]        ram_rdata_q;

    logic                  full_w;
    logic                  accept;
    logic                  io_sel;
    logic                  is_tx_addr;
    logic                  is_ctl_addr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  ram_re;
    logic                  io_rd;
    logic                  io_wr;
    logic                  push_req;
    logic                  push;
    logic                  drop;
    logic                  tx_valid;
    logic                  pop;
    logic                  fifo_empty;

    assign full_w      = FULL_EN && (count_q >= FULL_LVL);
    assign accept      = rdy_i && !full_w;
    assign io_sel      = (bus.mem_addr >= IO_BASE);
    assign is_tx_addr  = (bus.mem_addr == IO_TX_ADDR);
    assign is_ctl_addr = (bus.mem_addr == IO_CTL_ADDR);
    assign ram_idx     = bus.mem_addr[ADDR_WIDTH-1:0];

    assign ram_we   = accept &&  bus.mem_wr && !io_sel;
    assign ram_re   = accept && !bus.mem_wr && !io_sel;
    assign io_wr    = accept &&  bus.mem_wr &&  io_sel;
    assign io_rd    = accept && !bus.mem_wr &&  io_sel;

    assign push_req   = io_wr && is_tx_addr;
    assign push       = push_req && (count_q != DEPTH_C);
    assign drop       = push_req && (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign tx_valid   = !fifo_empty && (pace_q == '0);
    assign pop        = rdy_i && tx_valid && io_tx_ready_i;

    assign bus.io_buffer_full = full_w;
    assign bus.mem_dout       = dout_ram_q ? ram_rdata_q : io_dout_q;
    assign io_rx_pop_o        = !rst && io_rd && is_tx_addr && io_rx_valid_i;
    assign io_tx_valid_o      = tx_valid;
    assign io_tx_data_o       = fifo_mem[rd_ptr_q];
    assign sim_halt_o         = halt_q;
    assign io_overflow_o      = overflow_q;

    // RAM contents survive reset; the read port registers the byte for one-cycle latency.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.mem_din;
        end
        if (ram_re) begin
            ram_rdata_q <= ram[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_din;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pace_d     = pace_q;
        halt_d     = halt_q;
        overflow_d = overflow_q;
        dout_ram_d = dout_ram_q;
        io_dout_d  = io_dout_q;

        if (ram_re) begin
            dout_ram_d = 1'b1;
        end

        if (io_rd) begin
            dout_ram_d = 1'b0;
            if (is_tx_addr) begin
                io_dout_d = io_rx_valid_i ? io_rx_data_i : 8'h00;
            end else if (is_ctl_addr) begin
                io_dout_d = {7'b0, fifo_empty};
            end else begin
                io_dout_d = 8'h00;
            end
        end

        if (io_wr && is_ctl_addr) begin
            halt_d = 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Pacing only advances while the system is running.
        if (pop) begin
            pace_d = PACE_RELOAD;
        end else if (rdy_i && (pace_q != '0)) begin
            pace_d = pace_q - PACE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pace_q     <= '0;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
            dout_ram_q <= 1'b0;
            io_dout_q  <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pace_q     <= pace_d;
            halt_q     <= halt_d;
            overflow_q <= overflow_d;
            dout_ram_q <= dout_ram_d;
            io_dout_q  <= io_dout_d;
        end
    end

endmodule
